// File: rtl/mcache_pkg.sv
// Shared definitions for the packet-cache write path: arbiter FSM states,
// header field positions and cache capacity.
package mcache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        RECV  = 2'd2,
        DESC  = 2'd3
    } arbState_e;

    localparam int HDR_DEST_LSB = 0;
    localparam int HDR_DEST_MSB = 3;
    localparam int HDR_PRIO_LSB = 4;
    localparam int HDR_PRIO_MSB = 6;
    localparam int HDR_LEN_LSB  = 7;
    localparam int HDR_LEN_MSB  = 16;

    localparam int MCACHE_RAMWIDTH = 10;
    localparam int MCACHE_CAPACITY = (1 << MCACHE_RAMWIDTH) - 1;

    // One word is kept unused so a full cache never aliases an empty one.
    function automatic int capacityOf(input int ramWidth);
        return (1 << ramWidth) - 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: picks the first requester after the previous winner,
// wrapping around the channel list.
module rr_arbiter #(
    parameter int PORTNUM = 16,
    parameter int IDXW    = (PORTNUM > 1) ? $clog2(PORTNUM) : 1
) (
    input  logic [PORTNUM-1:0] req_i,
    input  logic [IDXW-1:0]    lastIdx_i,
    output logic [PORTNUM-1:0] grant_o,
    output logic [IDXW-1:0]    grantIdx_o,
    output logic               valid_o
);

    int cand;

    always_comb begin
        grant_o    = '0;
        grantIdx_o = '0;
        valid_o    = 1'b0;
        cand       = 0;
        for (int i = 1; i <= PORTNUM; i++) begin
            cand = int'(lastIdx_i) + i;
            if (cand >= PORTNUM) begin
                cand = cand - PORTNUM;
            end
            if (!valid_o && req_i[cand]) begin
                valid_o       = 1'b1;
                grantIdx_o    = IDXW'(cand);
                grant_o[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/port_wr_arb.sv
// Write-side arbiter for one output port: grants one input channel at a time,
// stores its beats into the packet cache and emits a descriptor per packet.
module port_wr_arb
    import mcache_pkg::*;
#(
    parameter int         PORTNUM  = 16,
    parameter int         DWIDTH   = 32,
    parameter int         RAMWIDTH = 10,
    parameter logic [3:0] PORT_ID  = 4'd0
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [PORTNUM-1:0]          i_req,
    input  logic [PORTNUM*DWIDTH-1:0]   i_data,
    input  logic [PORTNUM-1:0]          i_data_vld,
    input  logic [PORTNUM-1:0]          i_eop,
    input  logic                        i_free_vld,
    input  logic [RAMWIDTH-1:0]         i_free_num,
    input  logic                        i_desc_full,
    output logic [PORTNUM-1:0]          o_resp,
    output logic [PORTNUM-1:0]          o_nresp,
    output logic [RAMWIDTH-1:0]         o_ramspace,
    output logic                        o_ready,
    output logic                        o_wr_en,
    output logic [RAMWIDTH-1:0]         o_wr_addr,
    output logic [DWIDTH-1:0]           o_wr_data,
    output logic                        o_desc_vld,
    output logic [RAMWIDTH-1:0]         o_desc_addr,
    output logic [RAMWIDTH-1:0]         o_desc_len,
    output logic [2:0]                  o_desc_prio,
    output logic                        o_ovf
);

    localparam int IdxW = (PORTNUM > 1) ? $clog2(PORTNUM) : 1;
    localparam logic [RAMWIDTH-1:0] Cap = RAMWIDTH'(capacityOf(RAMWIDTH));
    localparam logic [IdxW-1:0] LastIdxInit = IdxW'(PORTNUM - 1);

    if (int'(PORT_ID) >= PORTNUM) begin : g_portIdCheck
        $error("port_wr_arb: PORT_ID must index one of the PORTNUM ports");
    end

    arbState_e              state_q,    state_d;
    logic [IdxW-1:0]        lastWin_q,  lastWin_d;
    logic [IdxW-1:0]        winIdx_q,   winIdx_d;
    logic [PORTNUM-1:0]     winOh_q,    winOh_d;
    logic [PORTNUM-1:0]     reqMask_q,  reqMask_d;
    logic [RAMWIDTH-1:0]    wrPtr_q,    wrPtr_d;
    logic [RAMWIDTH-1:0]    beatCnt_q,  beatCnt_d;
    logic [RAMWIDTH-1:0]    space_q,    space_d;
    logic                   wrEn_q,     wrEn_d;
    logic [RAMWIDTH-1:0]    wrAddr_q,   wrAddr_d;
    logic [DWIDTH-1:0]      wrData_q,   wrData_d;
    logic                   ovf_q,      ovf_d;
    logic [RAMWIDTH-1:0]    descAddr_q, descAddr_d;
    logic [2:0]             prio_q,     prio_d;

    logic [PORTNUM-1:0]     arbOh;
    logic [IdxW-1:0]        arbIdx;
    logic                   arbValid;

    logic                   beatVld;
    logic                   beatEop;
    logic [DWIDTH-1:0]      beatData;
    logic                   accept;
    logic [RAMWIDTH:0]      spaceSum;

    rr_arbiter #(
        .PORTNUM (PORTNUM),
        .IDXW    (IdxW)
    ) u_rrArbiter (
        .req_i      (i_req),
        .lastIdx_i  (lastWin_q),
        .grant_o    (arbOh),
        .grantIdx_o (arbIdx),
        .valid_o    (arbValid)
    );

    // Only the granted channel is visible to the receive path.
    assign beatVld  = i_data_vld[winIdx_q];
    assign beatEop  = i_eop[winIdx_q];
    assign beatData = i_data[winIdx_q*DWIDTH +: DWIDTH];
    assign accept   = (state_q == RECV) && beatVld && (space_q != '0);

    always_comb begin
        state_d    = state_q;
        lastWin_d  = lastWin_q;
        winIdx_d   = winIdx_q;
        winOh_d    = winOh_q;
        reqMask_d  = reqMask_q;
        wrPtr_d    = wrPtr_q;
        beatCnt_d  = beatCnt_q;
        wrEn_d     = 1'b0;
        wrAddr_d   = wrAddr_q;
        wrData_d   = wrData_q;
        ovf_d      = 1'b0;
        descAddr_d = descAddr_q;
        prio_d     = prio_q;

        case (state_q)
            IDLE: begin
                if (!i_desc_full && arbValid) begin
                    state_d   = GRANT;
                    winIdx_d  = arbIdx;
                    winOh_d   = arbOh;
                    reqMask_d = i_req;
                    lastWin_d = arbIdx;
                    beatCnt_d = '0;
                end
            end
            GRANT: begin
                state_d = RECV;
            end
            RECV: begin
                if (beatVld) begin
                    if (accept) begin
                        wrEn_d   = 1'b1;
                        wrAddr_d = wrPtr_q;
                        wrData_d = beatData;
                        wrPtr_d  = wrPtr_q + RAMWIDTH'(1);
                        if (beatCnt_q == '0) begin
                            descAddr_d = wrPtr_q;
                            prio_d     = beatData[HDR_PRIO_MSB:HDR_PRIO_LSB];
                        end
                        if (beatCnt_q != '1) begin
                            beatCnt_d = beatCnt_q + RAMWIDTH'(1);
                        end
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (beatEop) begin
                        state_d = DESC;
                    end
                end
            end
            DESC: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Write and release land in the same cycle; one spare bit catches overflow
    // of the sum so the result can be clamped to capacity.
    always_comb begin
        spaceSum = {1'b0, space_q}
                 - (accept ? (RAMWIDTH+1)'(1) : '0)
                 + (i_free_vld ? {1'b0, i_free_num} : '0);
        space_d  = spaceSum[RAMWIDTH] ? Cap : spaceSum[RAMWIDTH-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            lastWin_q  <= LastIdxInit;
            winIdx_q   <= '0;
            winOh_q    <= '0;
            reqMask_q  <= '0;
            wrPtr_q    <= '0;
            beatCnt_q  <= '0;
            space_q    <= Cap;
            wrEn_q     <= 1'b0;
            wrAddr_q   <= '0;
            wrData_q   <= '0;
            ovf_q      <= 1'b0;
            descAddr_q <= '0;
            prio_q     <= '0;
        end else begin
            state_q    <= state_d;
            lastWin_q  <= lastWin_d;
            winIdx_q   <= winIdx_d;
            winOh_q    <= winOh_d;
            reqMask_q  <= reqMask_d;
            wrPtr_q    <= wrPtr_d;
            beatCnt_q  <= beatCnt_d;
            space_q    <= space_d;
            wrEn_q     <= wrEn_d;
            wrAddr_q   <= wrAddr_d;
            wrData_q   <= wrData_d;
            ovf_q      <= ovf_d;
            descAddr_q <= descAddr_d;
            prio_q     <= prio_d;
        end
    end

    assign o_ready     = (state_q == IDLE) && !i_desc_full;
    assign o_resp      = (state_q == GRANT) ? winOh_q : '0;
    assign o_nresp     = (state_q == GRANT) ? (reqMask_q & ~winOh_q) : '0;
    assign o_ramspace  = space_q;
    assign o_wr_en     = wrEn_q;
    assign o_wr_addr   = wrAddr_q;
    assign o_wr_data   = wrData_q;
    assign o_ovf       = ovf_q;
    assign o_desc_vld  = (state_q == DESC);
    assign o_desc_addr = (state_q == DESC) ? descAddr_q : '0;
    assign o_desc_len  = (state_q == DESC) ? beatCnt_q : '0;
    assign o_desc_prio = (state_q == DESC) ? prio_q : '0;

endmodule

// File: tb/tb_port_wr_arb.sv
// Directed bench for port_wr_arb; expected cache writes and descriptors are
// queued as beats are driven and matched as the DUT emits them.
module tb_port_wr_arb;

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } wrExp_t;

    typedef struct {
        logic [9:0] addr;
        logic [9:0] len;
        logic [2:0] prio;
    } descExp_t;

    logic         i_clk;
    logic         i_rst_n;
    logic [15:0]  i_req;
    logic [511:0] i_data;
    logic [15:0]  i_data_vld;
    logic [15:0]  i_eop;
    logic         i_free_vld;
    logic [9:0]   i_free_num;
    logic         i_desc_full;
    logic [15:0]  o_resp;
    logic [15:0]  o_nresp;
    logic [9:0]   o_ramspace;
    logic         o_ready;
    logic         o_wr_en;
    logic [9:0]   o_wr_addr;
    logic [31:0]  o_wr_data;
    logic         o_desc_vld;
    logic [9:0]   o_desc_addr;
    logic [9:0]   o_desc_len;
    logic [2:0]   o_desc_prio;
    logic         o_ovf;

    int vectors = 0;
    int miscompares = 0;
    int ovfSeen = 0;
    int modelSpace = 1023;
    logic [9:0] modelPtr = '0;
    wrExp_t   wrQ[$];
    descExp_t descQ[$];

    port_wr_arb #(
        .PORTNUM  (16),
        .DWIDTH   (32),
        .RAMWIDTH (10),
        .PORT_ID  (4'd0)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req       (i_req),
        .i_data      (i_data),
        .i_data_vld  (i_data_vld),
        .i_eop       (i_eop),
        .i_free_vld  (i_free_vld),
        .i_free_num  (i_free_num),
        .i_desc_full (i_desc_full),
        .o_resp      (o_resp),
        .o_nresp     (o_nresp),
        .o_ramspace  (o_ramspace),
        .o_ready     (o_ready),
        .o_wr_en     (o_wr_en),
        .o_wr_addr   (o_wr_addr),
        .o_wr_data   (o_wr_data),
        .o_desc_vld  (o_desc_vld),
        .o_desc_addr (o_desc_addr),
        .o_desc_len  (o_desc_len),
        .o_desc_prio (o_desc_prio),
        .o_ovf       (o_ovf)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one cycle, then match any write/descriptor against the queues.
    task automatic step();
        wrExp_t   w;
        descExp_t d;
        @(posedge i_clk);
        #1;
        if (o_wr_en === 1'b1) begin
            if (wrQ.size() == 0) begin
                checkOutput("wr_unexpected", o_wr_en, 64'd0);
            end else begin
                w = wrQ.pop_front();
                checkOutput("wr_addr", o_wr_addr, w.addr);
                checkOutput("wr_data", o_wr_data, w.data);
            end
        end
        if (o_desc_vld === 1'b1) begin
            if (descQ.size() == 0) begin
                checkOutput("desc_unexpected", o_desc_vld, 64'd0);
            end else begin
                d = descQ.pop_front();
                checkOutput("desc_addr", o_desc_addr, d.addr);
                checkOutput("desc_len", o_desc_len, d.len);
                checkOutput("desc_prio", o_desc_prio, d.prio);
            end
        end
        if (o_ovf === 1'b1) ovfSeen++;
    endtask

    task automatic clearInputs();
        i_req      = '0;
        i_data     = '0;
        i_data_vld = '0;
        i_eop      = '0;
        i_free_vld = 1'b0;
        i_free_num = '0;
    endtask

    task automatic applyStimulus(input string tag, input int ch, input logic [15:0] reqMask,
                                 input logic [15:0] expResp, input logic [15:0] expNresp,
                                 input int nBeats, input logic [31:0] header,
                                 input int freeBeat, input int freeNum);
        int cnt;
        int expOvf;
        int ovfStart;
        int nc;
        logic [31:0] d;
        logic [9:0]  dAddr;
        logic [2:0]  dPrio;
        wrExp_t      w;
        descExp_t    de;
        cnt = 0;
        expOvf = 0;
        dAddr = '0;
        dPrio = '0;
        nc = (ch + 1) % 16;
        i_req = reqMask;
        step();
        checkOutput({tag, "_resp"}, o_resp, expResp);
        checkOutput({tag, "_nresp"}, o_nresp, expNresp);
        i_req = '0;
        step();
        ovfStart = ovfSeen;
        for (int i = 0; i < nBeats; i++) begin
            d = (i == 0) ? header : $urandom;
            if (i == 1) begin
                i_req = '0;
                i_data_vld = '0;
                i_eop = '0;
                i_data_vld[nc] = 1'b1;
                i_eop[nc] = 1'b1;
                step();
            end
            i_data_vld = '0;
            i_eop = '0;
            i_data_vld[nc] = 1'b1;
            i_eop[nc] = 1'b1;
            i_data[nc*32 +: 32] = ~d;
            i_data_vld[ch] = 1'b1;
            i_eop[ch] = (i == nBeats - 1);
            i_data[ch*32 +: 32] = d;
            i_req = (i == 0 && nBeats > 1) ? 16'hFFFF : 16'h0000;
            i_free_vld = (i == freeBeat);
            i_free_num = (i == freeBeat) ? 10'(freeNum) : 10'd0;
            if (modelSpace > 0) begin
                w.addr = modelPtr;
                w.data = d;
                wrQ.push_back(w);
                if (cnt == 0) begin
                    dAddr = modelPtr;
                    dPrio = d[6:4];
                end
                modelPtr = modelPtr + 10'd1;
                modelSpace--;
                if (cnt < 1023) cnt++;
            end else begin
                expOvf++;
            end
            if (i == freeBeat) begin
                modelSpace += freeNum;
                if (modelSpace > 1023) modelSpace = 1023;
            end
            if (i == nBeats - 1) begin
                de.addr = dAddr;
                de.len  = 10'(cnt);
                de.prio = dPrio;
                descQ.push_back(de);
            end
            step();
            checkOutput({tag, "_space"}, o_ramspace, modelSpace);
            if (i == 0 && nBeats > 1) begin
                checkOutput({tag, "_late_resp"}, o_resp, 64'd0);
                checkOutput({tag, "_late_nresp"}, o_nresp, 64'd0);
            end
        end
        clearInputs();
        step();
        checkOutput({tag, "_ovf"}, ovfSeen - ovfStart, expOvf);
        checkOutput({tag, "_idle_ready"}, o_ready, 64'd1);
    endtask

    initial begin
        wrExp_t w;
        clearInputs();
        i_rst_n = 1'b0;
        i_desc_full = 1'b0;
        step();
        step();
        checkOutput("rst_ready", o_ready, 64'd1);
        checkOutput("rst_space", o_ramspace, 64'd1023);
        checkOutput("rst_resp", o_resp, 64'd0);
        checkOutput("rst_nresp", o_nresp, 64'd0);
        checkOutput("rst_wr_en", o_wr_en, 64'd0);
        checkOutput("rst_wr_addr", o_wr_addr, 64'd0);
        checkOutput("rst_wr_data", o_wr_data, 64'd0);
        checkOutput("rst_desc_vld", o_desc_vld, 64'd0);
        checkOutput("rst_desc_addr", o_desc_addr, 64'd0);
        checkOutput("rst_ovf", o_ovf, 64'd0);
        i_rst_n = 1'b1;

        applyStimulus("p1", 0, 16'h0007, 16'h0001, 16'h0006, 6, 32'h0000_6460, -1, 0);
        checkOutput("p1_space_1017", o_ramspace, 64'd1017);
        applyStimulus("p2", 1, 16'h0007, 16'h0002, 16'h0005, 2, 32'h0000_0050, -1, 0);
        applyStimulus("p3", 3, 16'h0008, 16'h0008, 16'h0000, 3, 32'h0000_0020, 1, 5);
        checkOutput("p3_free_net", o_ramspace, 64'd1017);

        applyStimulus("fill", 4, 16'h0010, 16'h0010, 16'h0000, 1009, 32'h0000_0010, -1, 0);
        checkOutput("fill_space", o_ramspace, 64'd8);
        i_free_vld = 1'b1;
        i_free_num = 10'd1000;
        step();
        checkOutput("free_1000", o_ramspace, 64'd1008);
        step();
        checkOutput("free_clamp", o_ramspace, 64'd1023);
        clearInputs();
        modelSpace = 1023;

        applyStimulus("wrap", 5, 16'h0020, 16'h0020, 16'h0000, 8, 32'h0000_0030, -1, 0);
        applyStimulus("drain", 6, 16'h0040, 16'h0040, 16'h0000, 1013, 32'h0000_0000, -1, 0);
        checkOutput("drain_space", o_ramspace, 64'd2);
        applyStimulus("ovf", 7, 16'h0080, 16'h0080, 16'h0000, 4, 32'h0000_0040, -1, 0);
        checkOutput("ovf_space", o_ramspace, 64'd0);
        i_free_vld = 1'b1;
        i_free_num = 10'd1023;
        step();
        clearInputs();
        modelSpace = 1023;
        checkOutput("refill_space", o_ramspace, 64'd1023);

        i_desc_full = 1'b1;
        i_req = 16'h00F0;
        step();
        checkOutput("full_ready", o_ready, 64'd0);
        checkOutput("full_resp", o_resp, 64'd0);
        step();
        checkOutput("full_resp2", o_resp, 64'd0);
        checkOutput("full_nresp2", o_nresp, 64'd0);
        i_req = '0;
        step();
        i_desc_full = 1'b0;
        step();
        checkOutput("unfull_ready", o_ready, 64'd1);

        i_req = 16'h0004;
        step();
        checkOutput("rstpkt_resp", o_resp, 64'h0004);
        i_req = '0;
        step();
        for (int i = 0; i < 2; i++) begin
            i_data_vld[2] = 1'b1;
            i_data[2*32 +: 32] = 32'hA5A5_0000 + 32'(i);
            w.addr = modelPtr;
            w.data = 32'hA5A5_0000 + 32'(i);
            wrQ.push_back(w);
            modelPtr = modelPtr + 10'd1;
            step();
        end
        i_eop[2] = 1'b1;
        i_rst_n = 1'b0;
        step();
        checkOutput("rstpkt_space", o_ramspace, 64'd1023);
        checkOutput("rstpkt_ready", o_ready, 64'd1);
        checkOutput("rstpkt_desc", o_desc_vld, 64'd0);
        checkOutput("rstpkt_wr_en", o_wr_en, 64'd0);
        i_rst_n = 1'b1;
        clearInputs();
        modelSpace = 1023;
        modelPtr = '0;
        step();
        checkOutput("rstpkt_desc2", o_desc_vld, 64'd0);

        applyStimulus("post", 0, 16'h0007, 16'h0001, 16'h0006, 1, 32'h0000_0070, -1, 0);
        checkOutput("wrq_empty", wrQ.size(), 64'd0);
        checkOutput("descq_empty", descQ.size(), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/port_wr_arb.md
PORT_WR_ARB -- requirements
Module: port_wr_arb

Interface
REQ-001 Parameters SHALL be: PORTNUM, 16, number of input channels; DWIDTH, 32, data width; RAMWIDTH, 10, cache address width; PORT_ID, 4'd0, index of the output port this block serves.
REQ-002 i_clk  input  1  single clock; all logic SHALL be rising-edge.
REQ-003 i_rst_n  input  1  synchronous, active-low reset.
REQ-004 i_req  input  PORTNUM  bit k: channel k requests this port.
REQ-005 i_data  input  PORTNUM x DWIDTH  per-channel data beats.
REQ-006 i_data_vld  input  PORTNUM  per-channel beat valid.
REQ-007 i_eop  input  PORTNUM  per-channel last-beat flag, coincident with the last valid beat.
REQ-008 i_free_vld / i_free_num  input  1 / RAMWIDTH  read side releases i_free_num words.
REQ-009 i_desc_full  input  1  downstream descriptor queue full.
REQ-010 o_resp / o_nresp  output  PORTNUM / PORTNUM  grant / reject pulses per channel.
REQ-011 o_ramspace  output  RAMWIDTH  free words in the cache.
REQ-012 o_ready  output  1  port can accept a new grant.
REQ-013 o_wr_en / o_wr_addr / o_wr_data  output  1 / RAMWIDTH / DWIDTH  cache write port.
REQ-014 o_desc_vld / o_desc_addr / o_desc_len / o_desc_prio  output  1 / RAMWIDTH / RAMWIDTH / 3  packet descriptor.
REQ-015 o_ovf  output  1  one-cycle pulse when a beat is dropped for lack of space.

Function
REQ-016 FSM states SHALL be IDLE, GRANT, RECV, DESC.
REQ-017 o_ready SHALL be 1 only in IDLE with i_desc_full=0.
REQ-018 IDLE->GRANT SHALL occur when o_ready=1 and i_req!=0; the winner is chosen round-robin, starting at last_winner+1 mod PORTNUM.
REQ-019 In GRANT, for exactly one cycle: o_resp is one-hot on the winner; o_nresp is set for every other requesting channel. The FSM then moves to RECV.
REQ-020 Requests arriving while not in IDLE SHALL receive neither resp nor nresp.
REQ-021 In RECV, only the winner's i_data/i_data_vld/i_eop SHALL be observed; other channels are ignored.
REQ-022 Each winner beat with vld=1 and o_ramspace>0 SHALL produce o_wr_en=1 one cycle later, with o_wr_addr=wr_ptr; wr_ptr then increments modulo 2^RAMWIDTH.
REQ-023 A beat with o_ramspace=0 SHALL be dropped (no write, no pointer advance) and pulse o_ovf.
REQ-024 The first written beat of a packet is the header: prio=data[6:4]; its address is latched as the descriptor address.
REQ-025 The beat counter SHALL count written beats of the packet, saturating at 2^RAMWIDTH-1.
REQ-026 A winner beat with vld=1 and eop=1 SHALL cause RECV->DESC.
REQ-027 DESC SHALL assert o_desc_vld for one cycle with addr, len=beat count and prio, then go to IDLE.
REQ-028 Usable capacity SHALL be 2^RAMWIDTH-1 words; o_ramspace is next = space - write + (i_free_vld ? i_free_num : 0), clamped at 2^RAMWIDTH-1.
REQ-029 A simultaneous write and free SHALL both be applied in the same cycle.
REQ-030 A winner vld=0 in RECV SHALL hold state; there is no timeout.

Reset
REQ-031 Synchronous reset SHALL force: IDLE; last_winner=PORTNUM-1; wr_ptr=0; beat count=0; o_ramspace=2^RAMWIDTH-1.
REQ-032 Synchronous reset SHALL drive all of o_resp, o_nresp, o_wr_en, o_desc_vld, o_ovf and all data/address outputs to 0.
REQ-033 Reset asserted mid-packet SHALL abandon the packet with no descriptor issued.

Structure
REQ-034 The FSM state enum, the header field offsets (prio [6:4], len [16:7], dest [3:0]) and the capacity constant SHALL live in a shared package, mcache_pkg.
REQ-035 The round-robin selector SHALL be a sub-module, rr_arbiter, parameterised by PORTNUM.

Verification
REQ-036 Requests 0x0007 in IDLE -> channel 0 gets resp=0x0001 and nresp=0x0006; after its eop, a repeat of 0x0007 -> resp=0x0002.
REQ-037 Winner sends header 0x00006460 plus 5 beats, eop on the 6th -> 6 writes at addr 0..5, then desc addr=0, len=6, prio=6, and o_ramspace=1017.
REQ-038 Run wr_ptr to 1020 and send an 8-beat packet -> addresses 1020..1023,0..3, desc addr=1020.
REQ-039 o_ramspace=2 and a 4-beat packet -> 2 writes, 2 o_ovf pulses, desc len=2.
REQ-040 A write plus i_free_vld with num=5 in the same cycle -> o_ramspace increases by net 4.
REQ-041 i_desc_full=1 -> o_ready=0 and requests ungranted; reset mid-RECV -> IDLE with o_ramspace=1023 and no descriptor.
